uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the ports SHALL be named clock and reset.
REQ-002 Parameter CLOCK_DIV, default 104: system clock cycles per bit period, giving 9600 bps on the team's system clock; legal range 4 to 65535.
REQ-003 Port clock  input  1  system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous active-high reset.
REQ-005 Port rx  input  1  serial line, asynchronous to clock, idle high.
REQ-006 Port data_ack  input  1  consumer acknowledge; clears data_valid.
REQ-007 Port data_out  output  8  last received byte.
REQ-008 Port data_valid  output  1  data_out holds an unacknowledged byte.
REQ-009 Port busy  output  1  a frame is being received (state not IDLE).
REQ-010 Port frame_err  output  1  one-cycle pulse: the stop bit was sampled low.
REQ-011 Port overrun_err  output  1  one-cycle pulse: a byte completed while data_valid was still high.
REQ-012 Port parity_err  output  1  one-cycle pulse: parity mismatch; tied 0 when parity is compiled out.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value.
REQ-014 Frame format: 1 start bit (low), 8 data bits LSB first, optional parity bit, 1 stop bit (high).
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP; the bit counter SHALL be 16 bits wide and the bit index 3 bits wide.
REQ-016 IDLE: on a synchronized high-to-low transition, the block SHALL clear the counter and go to START.
REQ-017 START: when the counter reaches CLOCK_DIV/2-1 (integer division), the block SHALL sample the line.
- Low: clear the counter and go to DATA with index 0.
- High: false start; return to IDLE with no output pulse.
REQ-018 DATA: each time the counter reaches CLOCK_DIV-1, the block SHALL sample into the shift register at bit_idx and clear the counter.
- After bit 7: go to PARITY if parity is enabled, otherwise to STOP.
REQ-019 PARITY: at counter CLOCK_DIV-1, the block SHALL sample the parity bit, record the mismatch, and go to STOP.
REQ-020 STOP: at counter CLOCK_DIV-1, the block SHALL sample the stop bit and go to IDLE in the same cycle, so back-to-back frames are accepted.
REQ-021 Stop bit high: on the next cycle the block SHALL load data_out, set data_valid, and pulse parity_err if a mismatch was recorded.
REQ-022 Stop bit low: the block SHALL pulse frame_err, leave data_out and data_valid unchanged, and suppress parity_err.
REQ-023 data_valid SHALL stay high until a cycle with data_ack high, then clear on the next edge.
- data_ack while data_valid is low SHALL be ignored.
REQ-024 Byte completion while data_valid is high: the block SHALL overwrite data_out, keep data_valid high, and pulse overrun_err.
- If data_ack arrives in the same cycle, completion wins: data_valid stays high and no overrun_err is raised.
REQ-025 busy SHALL be high exactly when the state is not IDLE.
REQ-026 Latency: data_valid SHALL rise 1 cycle after the stop-bit sample.
- The stop-bit sample SHALL fall (CLOCK_DIV/2) + N*CLOCK_DIV cycles after falling-edge detection, where N is 9 without parity and 10 with it.

Reset
REQ-027 Reset SHALL force: state IDLE, counter 0, bit index 0, synchronizer flops 1, data_out 8'h00, data_valid 0, busy 0, and all error pulses 0.
REQ-028 Reset asserted mid-frame SHALL discard the partial byte; after release the block SHALL wait for a new falling edge.

Configuration
REQ-029 With UART_RX_PARITY_EN defined, the block SHALL expect an even-parity bit after data bit 7 and drive parity_err.
REQ-030 Without UART_RX_PARITY_EN, the PARITY state SHALL be unreachable and parity_err SHALL be constant 0.

Structure
REQ-031 Package uart_pkg SHALL hold the receiver state encoding (3-bit) and the CLOCK_DIV default constant 104.
REQ-032 The synchronizer SHALL be a sub-module named uart_sync2 (1-bit, 2 flops, reset to 1).

Verification
REQ-033 Byte 8'hA5, CLOCK_DIV=104, no parity -> data_out=8'hA5 and data_valid rises 1 cycle after the stop sample (52+9*104 cycles after edge detection); frame_err=0.
REQ-034 Low glitch of 20 cycles in IDLE -> return to IDLE at the mid-start sample; data_valid, frame_err and overrun_err all stay 0.
REQ-035 Frame 8'h3C with stop bit driven low -> frame_err pulses for 1 cycle; data_out keeps its previous value; data_valid unchanged.
REQ-036 Bytes 8'h11 then 8'h22 back-to-back with no data_ack -> overrun_err pulses on the second byte, data_out=8'h22, data_valid stays 1.
REQ-037 Reset asserted during data bit 4 of 8'hFF, then byte 8'h5A sent -> only 8'h5A is delivered.
REQ-038 UART_RX_PARITY_EN defined, 8'h07 sent with parity bit 0 (wrong) -> parity_err pulses, data_out=8'h07; with correct parity bit 1 -> no pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART receiver slice.
// Holds the 3-bit receiver state encoding and the default bit-period divider.
package uart_pkg;

   // System clock cycles per bit period: 9600 bps on the team system clock.
   localparam int CLOCK_DIV_DEFAULT = 104;

   // Receiver frame states; PARITY is only reachable with UART_RX_PARITY_EN.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

   // Even-parity bit for a data byte: the bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if -- byte handshake and status between the UART receiver and its consumer.
// The receiver side (master) drives the byte, its valid flag, busy and the error
// pulses; the consumer side (slave) returns data_ack.
interface uart_rx_if;

   logic [7:0] data_out;
   logic       data_valid;
   logic       data_ack;
   logic       busy;
   logic       frame_err;
   logic       overrun_err;
   logic       parity_err;

   modport master (
      output data_out,
      output data_valid,
      input  data_ack,
      output busy,
      output frame_err,
      output overrun_err,
      output parity_err
   );

   modport slave (
      input  data_out,
      input  data_valid,
      output data_ack,
      input  busy,
      input  frame_err,
      input  overrun_err,
      input  parity_err
   );

endinterface

// File: rtl/uart_sync2.sv
// uart_sync2 -- two-flop synchronizer for a single asynchronous input.
// Both flops reset to 1 so an idle-high serial line shows no edge on reset release.
module uart_sync2 (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   // Shift the asynchronous input through two flops to settle metastability.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with optional even parity.
// Build option: define UART_RX_PARITY_EN to expect an even-parity bit after data
// bit 7 and drive parity_err; otherwise the PARITY state is never entered and
// parity_err is tied low.
// Bits are sampled at mid-bit: the start bit at CLOCK_DIV/2 cycles after the
// falling edge is seen, every later bit a full CLOCK_DIV after the previous one.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLOCK_DIV = CLOCK_DIV_DEFAULT
) (
   input  logic      clock,
   input  logic      reset,
   input  logic      rx,
   uart_rx_if.master bus
);

   localparam logic [15:0] HALF_M1 = 16'(CLOCK_DIV / 2 - 1);
   localparam logic [15:0] FULL_M1 = 16'(CLOCK_DIV - 1);

   logic       rx_sync;
   logic       rx_prev;
   rx_state_t  state;
   logic [15:0] bit_cnt;
   logic [2:0] bit_idx;
   logic [7:0] shift_reg;
   logic       frame_ok;     // stop bit sampled high this cycle
   logic       frame_bad;    // stop bit sampled low this cycle
`ifdef UART_RX_PARITY_EN
   logic       par_mismatch; // parity of the current frame disagreed
`endif

   uart_sync2 u_sync2 (
      .clock (clock),
      .reset (reset),
      .d     (rx),
      .q     (rx_sync)
   );

   // Remember the previous synchronized level for falling-edge detection.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) rx_prev <= 1'b1;
      else       rx_prev <= rx_sync;
   end

   // Frame FSM: bit timing, data capture, and stop-bit verdict flags.
   // NOTE: every register here uses <= so all branches see the pre-edge values
   // of state, bit_cnt and bit_idx; a blocking update would leak into later tests.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         bit_cnt   <= 16'd0;
         bit_idx   <= 3'd0;
         // NOTE: the shift register is reset too; it is tiny, and a known value
         // keeps data_out deterministic even for a frame cut short by reset.
         shift_reg <= 8'h00;
         frame_ok  <= 1'b0;
         frame_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_mismatch <= 1'b0;
`endif
      end else begin
         frame_ok  <= 1'b0;
         frame_bad <= 1'b0;
         case (state)
            IDLE: begin
               if (rx_prev && !rx_sync) begin
                  bit_cnt <= 16'd0;
                  state   <= START;
               end
            end
            START: begin
               if (bit_cnt == HALF_M1) begin
                  bit_cnt <= 16'd0;
                  if (!rx_sync) begin
                     bit_idx <= 3'd0;
                     state   <= DATA;
                  end else begin
                     state   <= IDLE;   // line went back high: false start
                  end
               end else begin
                  bit_cnt <= bit_cnt + 16'd1;
               end
            end
            DATA: begin
               if (bit_cnt == FULL_M1) begin
                  bit_cnt            <= 16'd0;
                  shift_reg[bit_idx] <= rx_sync;
                  bit_idx            <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  bit_cnt <= bit_cnt + 16'd1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (bit_cnt == FULL_M1) begin
                  bit_cnt      <= 16'd0;
                  par_mismatch <= rx_sync ^ even_parity(shift_reg);
                  state        <= STOP;
               end else begin
                  bit_cnt <= bit_cnt + 16'd1;
               end
            end
`endif
            STOP: begin
               if (bit_cnt == FULL_M1) begin
                  bit_cnt   <= 16'd0;
                  frame_ok  <= rx_sync;
                  frame_bad <= ~rx_sync;
                  state     <= IDLE;    // ready for a back-to-back start bit
               end else begin
                  bit_cnt <= bit_cnt + 16'd1;
               end
            end
            default: begin
               bit_cnt <= 16'd0;
               state   <= IDLE;
            end
         endcase
      end
   end

   // Output stage: deliver the byte, manage the valid/ack handshake, raise pulses.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.data_out    <= 8'h00;
         bus.data_valid  <= 1'b0;
         bus.frame_err   <= 1'b0;
         bus.overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         bus.parity_err  <= 1'b0;
`endif
      end else begin
         bus.frame_err   <= frame_bad;
         bus.overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         bus.parity_err  <= 1'b0;
`endif
         if (frame_ok) begin
            // A completing byte wins over a same-cycle acknowledge.
            bus.data_out    <= shift_reg;
            bus.data_valid  <= 1'b1;
            bus.overrun_err <= bus.data_valid & ~bus.data_ack;
`ifdef UART_RX_PARITY_EN
            bus.parity_err  <= par_mismatch;
`endif
         end else if (bus.data_ack) begin
            bus.data_valid  <= 1'b0;
         end
      end
   end

`ifndef UART_RX_PARITY_EN
   assign bus.parity_err = 1'b0;
`endif

   // NOTE: busy is a plain continuous decode of the state register; a
   // combinational process with an incomplete assignment would infer a latch.
   assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed bench for uart_rx with CLOCK_DIV = 104.
// Honors UART_RX_PARITY_EN: frames then carry a parity bit and the parity cases run.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int D = CLOCK_DIV_DEFAULT;
   localparam int H = D / 2;
`ifdef UART_RX_PARITY_EN
   localparam int NBITS = 10;
`else
   localparam int NBITS = 9;
`endif
   // Edge detection to data_valid high: stop sample at H + NBITS*D, plus 1.
   localparam int LATENCY = H + NBITS * D + 1;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic rx    = 1'b1;

   uart_rx_if bus ();

   uart_rx #(.CLOCK_DIV(D)) dut (
      .clock (clock),
      .reset (reset),
      .rx    (rx),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Free-running posedge count and negedge-sampled event monitors.
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int dv_rises = 0, busy_rises = 0, fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, long_pulses = 0;
   int t_busy = 0, t_dv = 0;
   logic p_dv = 1'b0, p_busy = 1'b0, p_fe = 1'b0, p_ov = 1'b0, p_pe = 1'b0;

   always @(negedge clock) begin
      if (bus.data_valid && !p_dv) begin dv_rises <= dv_rises + 1; t_dv <= cyc; end
      if (bus.busy && !p_busy)     begin busy_rises <= busy_rises + 1; t_busy <= cyc; end
      if (bus.frame_err)   fe_cnt <= fe_cnt + 1;
      if (bus.overrun_err) ov_cnt <= ov_cnt + 1;
      if (bus.parity_err)  pe_cnt <= pe_cnt + 1;
      if ((bus.frame_err && p_fe) || (bus.overrun_err && p_ov) || (bus.parity_err && p_pe))
         long_pulses <= long_pulses + 1;
      p_dv   <= bus.data_valid;
      p_busy <= bus.busy;
      p_fe   <= bus.frame_err;
      p_ov   <= bus.overrun_err;
      p_pe   <= bus.parity_err;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      tick(D);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
      send_bit(par);
`else
      if (par === 1'bx) $display("parity bit unused in this build");
`endif
      send_bit(stop);
      rx = 1'b1;
   endtask

   task automatic ack_pulse();
      bus.data_ack = 1'b1;
      tick(1);
      bus.data_ack = 1'b0;
      tick(1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit seen_busy;
      bit done;
      bus.data_ack = 1'b0;

      // Reset state.
      tick(3);
      check("reset_busy", bus.busy, 1'b0);
      check("reset_dv", bus.data_valid, 1'b0);
      check("reset_data", bus.data_out, 8'h00);
      check("reset_errs", {bus.frame_err, bus.overrun_err, bus.parity_err}, 3'b000);
      reset = 1'b0;
      tick(5);
      check("idle_busy", bus.busy, 1'b0);

      // Clean byte A5 with latency measurement.
      send_frame(8'hA5, even_parity(8'hA5), 1'b1);
      tick(5);
      check("a5_data", bus.data_out, 8'hA5);
      check("a5_valid", bus.data_valid, 1'b1);
      check("a5_latency", t_dv - t_busy, LATENCY);
      check("a5_frame_err", fe_cnt, 0);
      check("a5_busy_done", bus.busy, 1'b0);
      ack_pulse();
      check("ack_clears", bus.data_valid, 1'b0);
      ack_pulse();
      check("ack_ignored", bus.data_valid, 1'b0);
      check("ack_no_rise", dv_rises, 1);

      // 20-cycle low glitch: false start.
      rx = 1'b0;
      tick(20);
      rx = 1'b1;
      tick(10);
      check("glitch_busy", bus.busy, 1'b1);
      tick(60);
      check("glitch_idle", bus.busy, 1'b0);
      check("glitch_dv", {bus.data_valid, 8'(dv_rises)}, {1'b0, 8'd1});
      check("glitch_errs", fe_cnt + ov_cnt, 0);

      // 3C with a low stop bit.
      send_frame(8'h3C, even_parity(8'h3C), 1'b0);
      tick(5);
      check("fe_count", fe_cnt, 1);
      check("fe_data_kept", bus.data_out, 8'hA5);
      check("fe_valid_kept", bus.data_valid, 1'b0);

      // 11 then 22 back to back, no acknowledge.
      send_frame(8'h11, even_parity(8'h11), 1'b1);
      send_frame(8'h22, even_parity(8'h22), 1'b1);
      tick(5);
      check("ovr_count", ov_cnt, 1);
      check("ovr_data", bus.data_out, 8'h22);
      check("ovr_valid", bus.data_valid, 1'b1);
      check("ovr_rises", dv_rises, 2);

      // 44 completes while data_valid is high and data_ack lands on the load cycle.
      seen_busy = 1'b0;
      done      = 1'b0;
      fork
         send_frame(8'h44, even_parity(8'h44), 1'b1);
         begin
            for (int i = 0; i < 2 * NBITS * D && !done; i++) begin
               @(negedge clock);
               if (bus.busy) seen_busy = 1'b1;
               else if (seen_busy) done = 1'b1;
            end
            if (done) begin
               bus.data_ack = 1'b1;
               @(posedge clock);
               #1;
               bus.data_ack = 1'b0;
            end
         end
      join
      check("race_seen", done, 1'b1);
      tick(5);
      check("race_valid", bus.data_valid, 1'b1);
      check("race_data", bus.data_out, 8'h44);
      check("race_no_ovr", ov_cnt, 1);
      check("race_rises", dv_rises, 2);
      ack_pulse();
      check("race_ack", bus.data_valid, 1'b0);

      // Reset during data bit 4 of FF, then 5A.
      fork
         send_frame(8'hFF, even_parity(8'hFF), 1'b1);
         begin
            tick(5 * D + H + 3);
            reset = 1'b1;
            tick(3);
            check("mid_rst_busy", bus.busy, 1'b0);
            check("mid_rst_data", bus.data_out, 8'h00);
            reset = 1'b0;
         end
      join
      tick(10);
      check("post_rst_dv", bus.data_valid, 1'b0);
      send_frame(8'h5A, even_parity(8'h5A), 1'b1);
      tick(5);
      check("5a_data", bus.data_out, 8'h5A);
      check("5a_rises", dv_rises, 3);
      ack_pulse();

`ifdef UART_RX_PARITY_EN
      // 07 with a wrong parity bit, then with the right one.
      send_frame(8'h07, 1'b0, 1'b1);
      tick(5);
      check("par_bad_pulse", pe_cnt, 1);
      check("par_bad_data", bus.data_out, 8'h07);
      ack_pulse();
      send_frame(8'h07, 1'b1, 1'b1);
      tick(5);
      check("par_ok_pulse", pe_cnt, 1);
      check("par_ok_valid", bus.data_valid, 1'b1);
`else
      check("par_tied_low", pe_cnt, 0);
`endif

      check("fe_total", fe_cnt, 1);
      check("pulse_width", long_pulses, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
